// File: rtl/video_rx_monitor_if.sv
// rtl/video_rx_monitor_if.sv - pixel stream and Avalon-MM register bus bundle for video_rx_monitor
interface video_rx_monitor_if;
    logic [23:0] video_RGB_IN;
    logic        video_HD;
    logic        video_VD;
    logic        video_DEN;
    logic [2:0]  avs_address;
    logic        avs_read;
    logic        avs_write;
    logic [31:0] avs_writedata;
    logic [31:0] avs_readdata;
    logic        irq;

    modport master (
        output video_RGB_IN, video_HD, video_VD, video_DEN,
        output avs_address, avs_read, avs_write, avs_writedata,
        input  avs_readdata, irq
    );

    modport slave (
        input  video_RGB_IN, video_HD, video_VD, video_DEN,
        input  avs_address, avs_read, avs_write, avs_writedata,
        output avs_readdata, irq
    );
endinterface

// File: rtl/video_rx_monitor.sv
// rtl/video_rx_monitor.sv - video stream geometry/signature monitor with register file
// Optional frame CRC-32 in register 7 when VIDEO_RX_MONITOR_CRC_EN is defined.
module video_rx_monitor #(
    parameter bit SYNC_ACTIVE_LOW = 1'b1,
    parameter int CNT_W           = 12
) (
    input  logic              clk_clk,
    input  logic              reset_reset_n,
    video_rx_monitor_if.slave bus
);

    typedef enum logic [1:0] {IDLE, SEEK, CAPTURE} state_t;

    localparam logic [31:0] CRC_INIT = 32'hFFFF_FFFF;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

`ifdef VIDEO_RX_MONITOR_CRC_EN
    function automatic logic [31:0] crc_step(input logic [31:0] c, input logic [23:0] d);
        logic [31:0] r;
        logic        fb;
        r = c;
        for (int i = 23; i >= 0; i--) begin
            fb = r[31] ^ d[i];
            r  = {r[30:0], 1'b0};
            if (fb) r = r ^ 32'h04C1_1DB7;
        end
        return r;
    endfunction
`endif

    // input stage
    logic [23:0] rgb_q;
    logic        hd_q, vd_q, den_q;
    logic        hd_act_d, vd_act_d;
    logic        hd_act, vd_act, hd_edge, vd_edge;

    // register file
    logic             enable, frame_done, error, locked, irq_en;
    logic [CNT_W-1:0] width_r, height_r, htotal_r, vtotal_r;
    logic [15:0]      frames_r;
    logic [31:0]      checksum_r;
    logic             have_prev;
    logic [31:0]      rd_mux;

    // frame accumulators
    state_t           state;
    logic [CNT_W-1:0] pix_cnt, ref_w, line_cnt, vtot_cnt, htot_cnt;
    logic [31:0]      sum;
    logic             frame_bad;

    logic             live, running, new_frame, frame_latch;
    logic             line_close, first_line, line_bad, bad_cl, lock_d;
    logic [CNT_W-1:0] ref_w_cl, line_cnt_cl, vtot_cl, pix_start;
    logic [31:0]      pix;
    logic             ctrl_wr;
    logic             unused_wdata;

`ifdef VIDEO_RX_MONITOR_CRC_EN
    logic [31:0] crc, crc_r, crc_start;
`endif

    assign hd_act  = hd_q ^ SYNC_ACTIVE_LOW;
    assign vd_act  = vd_q ^ SYNC_ACTIVE_LOW;
    assign hd_edge = hd_act & ~hd_act_d;
    assign vd_edge = vd_act & ~vd_act_d;

    assign ctrl_wr      = bus.avs_write && (bus.avs_address == 3'd0);
    assign unused_wdata = ^{bus.avs_writedata[31:5], bus.avs_writedata[3]};
    assign bus.irq      = frame_done & irq_en;

    // A coincident HD edge closes its line before the VD edge closes the frame,
    // so the frame latch uses the *_cl values rather than the registered ones.
    always_comb begin
        live        = enable && (state == CAPTURE);
        running     = live && !vd_edge;
        new_frame   = enable && vd_edge && (state == SEEK || state == CAPTURE);
        frame_latch = live && vd_edge;
        pix         = den_q ? {8'h00, rgb_q} : 32'h0;
        pix_start   = den_q ? CNT_W'(1) : '0;
        line_close  = live && hd_edge && (pix_cnt != '0);
        first_line  = (line_cnt == '0);
        line_bad    = line_close && !first_line && (pix_cnt != ref_w);
        ref_w_cl    = (line_close && first_line) ? pix_cnt : ref_w;
        line_cnt_cl = line_close ? sat_inc(line_cnt) : line_cnt;
        vtot_cl     = (live && hd_edge) ? sat_inc(vtot_cnt) : vtot_cnt;
        bad_cl      = frame_bad || line_bad;
        lock_d      = !bad_cl && have_prev && (ref_w_cl == width_r) && (line_cnt_cl == height_r);
    end

`ifdef VIDEO_RX_MONITOR_CRC_EN
    assign crc_start = den_q ? crc_step(CRC_INIT, rgb_q) : CRC_INIT;
`endif

    always_comb begin
        rd_mux = 32'h0;
        case (bus.avs_address)
            3'd0: rd_mux = {27'd0, irq_en, locked, error, frame_done, enable};
            3'd1: rd_mux = {{(32-CNT_W){1'b0}}, width_r};
            3'd2: rd_mux = {{(32-CNT_W){1'b0}}, height_r};
            3'd3: rd_mux = {{(32-CNT_W){1'b0}}, htotal_r};
            3'd4: rd_mux = {{(32-CNT_W){1'b0}}, vtotal_r};
            3'd5: rd_mux = {16'd0, frames_r};
            3'd6: rd_mux = checksum_r;
`ifdef VIDEO_RX_MONITOR_CRC_EN
            3'd7: rd_mux = crc_r;
`else
            3'd7: rd_mux = 32'h0;
`endif
            default: rd_mux = 32'h0;
        endcase
    end

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            rgb_q    <= '0;
            hd_q     <= 1'b0;
            vd_q     <= 1'b0;
            den_q    <= 1'b0;
            hd_act_d <= 1'b0;
            vd_act_d <= 1'b0;
        end else begin
            rgb_q    <= bus.video_RGB_IN;
            hd_q     <= bus.video_HD;
            vd_q     <= bus.video_VD;
            den_q    <= bus.video_DEN;
            hd_act_d <= hd_act;
            vd_act_d <= vd_act;
        end
    end

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            state            <= IDLE;
            enable           <= 1'b0;
            frame_done       <= 1'b0;
            error            <= 1'b0;
            locked           <= 1'b0;
            irq_en           <= 1'b0;
            have_prev        <= 1'b0;
            width_r          <= '0;
            height_r         <= '0;
            htotal_r         <= '0;
            vtotal_r         <= '0;
            frames_r         <= '0;
            checksum_r       <= '0;
            bus.avs_readdata <= '0;
            pix_cnt          <= '0;
            ref_w            <= '0;
            line_cnt         <= '0;
            vtot_cnt         <= '0;
            htot_cnt         <= '0;
            sum              <= '0;
            frame_bad        <= 1'b0;
`ifdef VIDEO_RX_MONITOR_CRC_EN
            crc              <= '0;
            crc_r            <= '0;
`endif
        end else begin
            if (ctrl_wr) begin
                enable <= bus.avs_writedata[0];
                irq_en <= bus.avs_writedata[4];
            end
            // sticky status: a set event beats a same-cycle W1C
            if (frame_latch)
                frame_done <= 1'b1;
            else if (ctrl_wr && bus.avs_writedata[1])
                frame_done <= 1'b0;
            if (line_bad)
                error <= 1'b1;
            else if (ctrl_wr && bus.avs_writedata[2])
                error <= 1'b0;

            if (bus.avs_read)
                bus.avs_readdata <= rd_mux;

            if (!enable) begin
                state <= IDLE;
            end else begin
                case (state)
                    IDLE:    state <= SEEK;
                    SEEK:    if (vd_edge) state <= CAPTURE;
                    CAPTURE: state <= CAPTURE;
                    default: state <= IDLE;
                endcase
            end

            if (!enable)
                locked <= 1'b0;
            else if (frame_latch)
                locked <= lock_d;

            if (frame_latch) begin
                width_r    <= ref_w_cl;
                height_r   <= line_cnt_cl;
                vtotal_r   <= vtot_cl;
                checksum_r <= sum;
                frames_r   <= frames_r + 16'd1;
                have_prev  <= 1'b1;
`ifdef VIDEO_RX_MONITOR_CRC_EN
                crc_r      <= crc;
`endif
            end

            if (live && hd_edge)
                htotal_r <= htot_cnt;
            htot_cnt <= (enable && state != IDLE) ? (hd_edge ? CNT_W'(1) : sat_inc(htot_cnt)) : '0;

            // a DEN cycle on the frame edge seeds the new frame
            if (new_frame)
                pix_cnt <= pix_start;
            else if (running)
                pix_cnt <= hd_edge ? pix_start : (den_q ? sat_inc(pix_cnt) : pix_cnt);
            else
                pix_cnt <= '0;

            ref_w     <= running ? ref_w_cl : '0;
            line_cnt  <= running ? line_cnt_cl : '0;
            vtot_cnt  <= running ? vtot_cl : '0;
            frame_bad <= running ? bad_cl : 1'b0;
            sum       <= new_frame ? pix : (running ? sum + pix : 32'h0);
`ifdef VIDEO_RX_MONITOR_CRC_EN
            if (new_frame)
                crc <= crc_start;
            else if (running)
                crc <= den_q ? crc_step(crc, rgb_q) : crc;
            else
                crc <= CRC_INIT;
`endif
        end
    end

endmodule

// File: tb/tb_video_rx_monitor.sv
// tb/tb_video_rx_monitor.sv - scoreboard bench for video_rx_monitor
module tb_video_rx_monitor;

    localparam bit SYNC_LOW = 1'b1;
`ifdef VIDEO_RX_MONITOR_CRC_EN
    localparam logic [31:0] EMPTY_CRC = 32'hFFFF_FFFF;
`else
    localparam logic [31:0] EMPTY_CRC = 32'h0000_0000;
`endif

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    video_rx_monitor_if bus ();

    video_rx_monitor dut (
        .clk_clk       (clk),
        .reset_reset_n (rst_n),
        .bus           (bus)
    );

    int total = 0;
    int bad   = 0;

    string       tag_q[$];
    logic [31:0] exp_q[$];
    logic        rd_fire = 1'b0;
    string       mon_tag;
    logic [31:0] mon_exp;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h want 0x%08h", tag, got, exp);
        end
    endtask

    always @(posedge clk) rd_fire <= bus.avs_read && rst_n;

    always @(negedge clk) begin
        if (rd_fire) begin
            if (exp_q.size() == 0) begin
                check("sb_underflow", 32'(exp_q.size()), 32'd1);
            end else begin
                mon_tag = tag_q.pop_front();
                mon_exp = exp_q.pop_front();
                check(mon_tag, bus.avs_readdata, mon_exp);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    task automatic rd(input logic [2:0] a, input logic [31:0] e, input string t);
        bus.avs_address = a;
        bus.avs_read    = 1'b1;
        tag_q.push_back(t);
        exp_q.push_back(e);
        tick();
        bus.avs_read = 1'b0;
    endtask

    task automatic wr(input logic [2:0] a, input logic [31:0] d);
        bus.avs_address   = a;
        bus.avs_writedata = d;
        bus.avs_write     = 1'b1;
        tick();
        bus.avs_write = 1'b0;
    endtask

    task automatic set_video(input bit hd_a, input bit vd_a, input bit den, input logic [23:0] rgb);
        bus.video_HD     = hd_a ^ SYNC_LOW;
        bus.video_VD     = vd_a ^ SYNC_LOW;
        bus.video_DEN    = den;
        bus.video_RGB_IN = rgb;
    endtask

    // 12 clocks per line, VD with HD at line 0, active lines 1..4 with 8 pixels at columns 2..9
    task automatic frame(input int bad_line, input bit den_on, input bit w1c, input int nlines);
        bit den;
        for (int l = 0; l < nlines; l++) begin
            for (int c = 0; c < 12; c++) begin
                den = den_on && (l >= 1) && (l <= 4) && (c >= 2) && (c < 2 + ((l == bad_line) ? 7 : 8));
                set_video(c < 2, (l == 0) && (c < 4), den, den ? 24'h000001 : 24'($urandom));
                if (w1c && l == 0 && c == 1) begin
                    bus.avs_address   = 3'd0;
                    bus.avs_writedata = 32'h13;
                    bus.avs_write     = 1'b1;
                end else begin
                    bus.avs_write = 1'b0;
                end
                tick();
            end
        end
        set_video(1'b0, 1'b0, 1'b0, 24'h0);
        bus.avs_write = 1'b0;
    endtask

    initial begin
        set_video(1'b0, 1'b0, 1'b0, 24'h0);
        bus.avs_address   = 3'd0;
        bus.avs_read      = 1'b0;
        bus.avs_write     = 1'b0;
        bus.avs_writedata = 32'h0;

        idle(4);
        check("rst_irq", 32'(bus.irq), 32'd0);
        rst_n = 1'b1;
        idle(2);
        for (int i = 0; i < 8; i++) rd(3'(i), 32'h0, $sformatf("rst_reg%0d", i));

        // steady 8x4 stream
        wr(3'd0, 32'h01);
        idle(2);
        repeat (4) frame(-1, 1'b1, 1'b0, 6);
        idle(4);
        rd(3'd1, 32'd8,  "width");
        rd(3'd2, 32'd4,  "height");
        rd(3'd3, 32'd12, "htotal");
        rd(3'd4, 32'd6,  "vtotal");
        rd(3'd5, 32'd3,  "frames");
        rd(3'd6, 32'd32, "checksum");
        rd(3'd0, 32'h0B, "ctrl_locked");
        check("irq_off", 32'(bus.irq), 32'd0);

        // short line 3
        frame(3, 1'b1, 1'b0, 6);
        frame(-1, 1'b1, 1'b0, 6);
        idle(4);
        rd(3'd0, 32'h07, "ctrl_err");
        rd(3'd1, 32'd8,  "bad_width");
        rd(3'd2, 32'd4,  "bad_height");
        rd(3'd6, 32'd31, "bad_checksum");
        rd(3'd5, 32'd5,  "bad_frames");
        wr(3'd0, 32'h05);
        rd(3'd0, 32'h03, "ctrl_err_clr");

        // W1C of frame_done on the latch edge
        wr(3'd0, 32'h11);
        idle(1);
        check("irq_on", 32'(bus.irq), 32'd1);
        frame(-1, 1'b1, 1'b1, 6);
        check("w1c_irq", 32'(bus.irq), 32'd1);
        rd(3'd0, 32'h1B, "w1c_ctrl");
        rd(3'd5, 32'd6,  "w1c_frames");

        // disable mid-frame, then re-enable
        frame(-1, 1'b1, 1'b0, 3);
        wr(3'd0, 32'h10);
        idle(2);
        rd(3'd0, 32'h12, "dis_ctrl");
        rd(3'd5, 32'd7,  "dis_frames");
        rd(3'd1, 32'd8,  "dis_width");
        wr(3'd0, 32'h11);
        idle(2);
        frame(-1, 1'b1, 1'b0, 6);
        idle(4);
        rd(3'd5, 32'd7,  "reen_seek_frames");
        frame(-1, 1'b1, 1'b0, 6);
        idle(4);
        rd(3'd5, 32'd8,  "reen_frames");
        rd(3'd0, 32'h1B, "reen_ctrl");

        // reset mid-frame
        frame(-1, 1'b1, 1'b0, 3);
        rst_n = 1'b0;
        idle(2);
        check("rst2_irq", 32'(bus.irq), 32'd0);
        rst_n = 1'b1;
        idle(2);
        for (int i = 0; i < 8; i++) rd(3'(i), 32'h0, $sformatf("rst2_reg%0d", i));

        // frames without DEN
        wr(3'd0, 32'h01);
        idle(2);
        frame(-1, 1'b0, 1'b0, 6);
        frame(-1, 1'b0, 1'b0, 6);
        idle(4);
        rd(3'd1, 32'd0,  "empty_width");
        rd(3'd2, 32'd0,  "empty_height");
        rd(3'd4, 32'd6,  "empty_vtotal");
        rd(3'd5, 32'd1,  "empty_frames");
        rd(3'd6, 32'd0,  "empty_checksum");
        rd(3'd7, EMPTY_CRC, "empty_crc");

        idle(4);
        check("sb_empty", 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/video_rx_monitor.md
# video_rx_monitor

Receive-side companion to the LCD video output port: sinks the 24-bit RGB / HD / VD / DEN pixel stream, measures frame geometry, and accumulates a per-frame pixel signature. Results sit in an Avalon-MM slave register file, so software or a loopback bench can verify the video pipeline. It sits on the video clock domain, next to the video output in the QSYS system.

## Interface
Parameters:
- SYNC_ACTIVE_LOW, 1, HD/VD asserted low when 1, high when 0.
- CNT_W, 12, width of all geometry counters.

Ports:
- clk_clk  in  1  pixel clock; the only clock.
- reset_reset_n  in  1  asynchronous, active-low reset.
- video_RGB_IN  in  24  pixel data, sampled when video_DEN is high.
- video_HD  in  1  horizontal sync.
- video_VD  in  1  vertical sync.
- video_DEN  in  1  data enable.
- avs_address  in  3  word address.
- avs_read  in  1  read strobe.
- avs_write  in  1  write strobe.
- avs_writedata  in  32  write data.
- avs_readdata  out  32  read data, registered.
- irq  out  1  frame_done AND irq_en.

## Operation
- Inputs pass through one register stage. A leading edge is the transition to the asserted level, evaluated on the registered copies.
- Registers (word address):
  - 0 CTRL: bit0 enable (RW), bit1 frame_done (sticky, W1C), bit2 error (sticky, W1C), bit3 locked (RO), bit4 irq_en (RW).
  - 1 WIDTH, 2 HEIGHT, 3 HTOTAL, 4 VTOTAL (CNT_W bits, zero-extended).
  - 5 FRAMES, 16-bit, wraps.
  - 6 CHECKSUM.
  - 7 CRC (see Configuration).
- States:
  - IDLE: enable=0. Accumulators held at 0.
  - SEEK: enable=1. Waits for a VD leading edge, then goes to CAPTURE. That first edge does not count as a frame.
  - CAPTURE: accumulates. On every VD leading edge it latches the results, sets frame_done, increments FRAMES, clears the accumulators, and stays in CAPTURE.
- Clearing enable: any state goes to IDLE next cycle. Latched registers are retained. locked clears.
- Per-line accumulation in CAPTURE:
  - pix_cnt counts DEN-high cycles in the line.
  - On an HD leading edge with pix_cnt>0, the line is counted. The first counted line of a frame sets the reference width. A later line whose pix_cnt differs from the reference sets error and marks the frame bad. pix_cnt then clears.
  - htot counts clocks between HD leading edges and latches into HTOTAL at each edge.
  - vtot counts HD leading edges between VD leading edges.
- A coincident HD and VD edge closes the current line first, then the frame.
- Frame latch:
  - WIDTH = reference width, HEIGHT = counted lines, VTOTAL = vtot, CHECKSUM = sum.
  - locked = 1 if the frame is not bad and WIDTH/HEIGHT equal those of the previous completed frame; otherwise 0.
- CHECKSUM is the sum over DEN cycles of {8'h00, RGB}, mod 2^32.
- All counters saturate at 2^CNT_W-1.
- W1C: writing 1 clears the bit. If a set event and a W1C occur in the same cycle, the set wins.
- Unmapped or RO write bits are ignored. Address 7 reads 0 when CRC is compiled out.

## Timing
- Reset: every register, avs_readdata, irq = 0; state IDLE.
- Read latency: 1 cycle. avs_readdata is valid on the cycle after avs_read and holds until the next read.
- A write takes effect at the clock edge it is sampled on.
- Frame latch: results and frame_done are visible 2 cycles after the VD leading edge appears on the pins (1 input stage + 1 latch). irq follows in the same cycle.
- Pixel input to accumulator: 2 cycles. A DEN cycle coincident with a VD edge on the registered inputs belongs to the new frame.
- Reset mid-frame: immediate return to reset values. No partial frame is latched.

## Configuration
- VIDEO_RX_MONITOR_CRC_EN:
  - Defined: register 7 holds a CRC-32 of the frame, latched with the other results. Polynomial 0x04C11DB7, non-reflected, 24 bits per DEN cycle MSB first, init 0xFFFFFFFF, no final XOR.
  - Undefined: no CRC logic, and register 7 reads 0.

## Test plan
- Enable; drive 4 VD edges of 8x4 active pixels, HTOTAL 12, VTOTAL 6, RGB=0x000001 -> WIDTH=8, HEIGHT=4, HTOTAL=12, VTOTAL=6, CHECKSUM=32, FRAMES=3, locked=1 after the 2nd completed frame.
- Same stream with line 3 carrying 7 DEN cycles -> error=1, locked=0; write CTRL=0x05 -> error=0, enable stays 1.
- W1C of frame_done in the same cycle as a frame latch -> frame_done reads 1. With irq_en=1, irq stays high.
- Clear enable mid-frame -> IDLE, locked=0, FRAMES unchanged. Re-enable followed by one VD edge -> FRAMES unchanged. The next VD edge -> FRAMES+1.
- Assert reset_reset_n=0 mid-frame -> all registers read 0, irq=0.
- Frame with DEN never high -> HEIGHT=0, CHECKSUM=0. Register 7 reads 0xFFFFFFFF with VIDEO_RX_MONITOR_CRC_EN and 0 without.
